mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, 4, consecutive data grants allowed while a fetch waits (used only with ARB_STARVE_GUARD_EN).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 if_req  in  1  fetch request; held high until if_valid.
REQ-007 if_addr  in  ADDR_W  fetch address; stable while if_req is high.
REQ-008 if_flush  in  1  fetch redirect from the hazard unit (taken branch/jump); cancels the current fetch.
REQ-009 if_valid / if_rdata  out  1 / DATA_W  fetch response pulse and instruction word.
REQ-010 mem_req, mem_we  in  1, 1  data-access request and write select; held until mem_valid.
REQ-011 mem_addr, mem_wdata, mem_be  in  ADDR_W, DATA_W, DATA_W/8  data-access fields; stable while mem_req is high.
REQ-012 mem_valid / mem_rdata  out  1 / DATA_W  data response pulse (write acknowledge when mem_we) and load data.
REQ-013 if_stall, mem_stall  out  1, 1  stall requests to the pipeline hazard logic.
REQ-014 bus_req, bus_we, bus_addr, bus_wdata, bus_be  out  1, 1, ADDR_W, DATA_W, DATA_W/8  single shared memory port command.
REQ-015 bus_gnt  in  1  memory accepts the command in the cycle bus_req and bus_gnt are both high.
REQ-016 bus_rvalid / bus_rdata  in  1 / DATA_W  memory response, one per accepted command, at least one cycle after acceptance.

Function
REQ-017 FSM states SHALL be IDLE, REQ_IF, REQ_MEM, WAIT_IF, WAIT_MEM; one command SHALL be outstanding at a time.
REQ-018 IDLE: mem_req high -> REQ_MEM; else if_req high and if_flush low -> REQ_IF; else stay. The selected requester's fields SHALL be latched on this transition.
REQ-019 REQ_x: bus_req=1 with the latched fields held stable; on bus_gnt -> WAIT_x; otherwise stay.
REQ-020 WAIT_x: on bus_rvalid, drive x_valid=1 for exactly one cycle with x_rdata=bus_rdata, then -> IDLE; minimum request-to-valid latency is 3 cycles.
REQ-021 bus_we SHALL be 0 for fetches; bus_wdata and bus_be SHALL be 0 when bus_req is low.
REQ-022 if_stall = if_req & ~if_valid; mem_stall = mem_req & ~mem_valid (combinational).
REQ-023 if_flush in REQ_IF without bus_gnt -> IDLE, no bus transfer.
REQ-024 if_flush in WAIT_IF, or in REQ_IF coinciding with bus_gnt, SHALL set a drop flag; the matching bus_rvalid SHALL be consumed with if_valid suppressed, then -> IDLE.
REQ-025 if_flush SHALL have no effect on data accesses.
REQ-026 bus_rvalid in IDLE, REQ_IF or REQ_MEM SHALL be ignored.
REQ-027 if_rdata and mem_rdata SHALL be 0 whenever the matching valid is low.

Reset
REQ-028 reset SHALL force IDLE immediately, clear the drop flag, the latched fields and the starvation counter, and drive all outputs to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it; a late bus_rvalid after deassertion SHALL be ignored per REQ-026.

Configuration
REQ-030 Macro ARB_STARVE_GUARD_EN defined: a counter SHALL count data grants accepted while if_req is high, clear on a fetch grant or when if_req is low, and at STARVE_MAX the IDLE choice SHALL favour the fetch.
REQ-031 Macro undefined: strict data priority per REQ-018; no counter logic present.

Structure
REQ-032 State enum arb_state_t and the STARVE_MAX default SHALL reside in the shared core package core_pkg.
REQ-033 The single-cycle fixed-priority/starvation selector SHALL be sub-module arb_select; everything else is flat.

Verification
REQ-034 Fetch only, addr 0x100, bus_gnt immediate, rvalid one cycle after acceptance with 0x00500093 -> if_valid in cycle 3 with that data, if_stall high cycles 0-2.
REQ-035 if_req and mem_req in the same cycle (load 0x2000) -> data served first; fetch command issued only after mem_valid.
REQ-036 bus_gnt held low 5 cycles in REQ_MEM write 0xDEADBEEF, be 0xF -> bus fields stable all 5 cycles, single acceptance.
REQ-037 if_flush pulsed in WAIT_IF -> response consumed, no if_valid; next fetch for the new address proceeds normally.
REQ-038 ARB_STARVE_GUARD_EN, STARVE_MAX=4, mem_req continuously high with if_req -> fetch granted after 4 data grants.
REQ-039 Reset asserted in WAIT_MEM, then rvalid after release -> bus_req 0, mem_valid never asserted, state IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: memory-port arbiter FSM states and the default
// starvation limit used by mem_port_arbiter.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ_IF   = 3'd1,
    REQ_MEM  = 3'd2,
    WAIT_IF  = 3'd3,
    WAIT_MEM = 3'd4
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_select.sv
// Single-cycle requester choice for the memory-port arbiter: data accesses win
// unless the starvation limit has been reached while a fetch is waiting.
module arb_select (
  input  logic mem_req,
  input  logic if_req,
  input  logic starve_hit,
  output logic pick_mem,
  output logic pick_if
);

  assign pick_mem = mem_req & ~(starve_hit & if_req);
  assign pick_if  = if_req & ~pick_mem;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// command outstanding. Optional fetch starvation guard: ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                mem_valid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall,
  output logic                mem_stall,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W = DATA_W / 8;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_t        state_q, state_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arb_open, starve_hit, pick_mem, pick_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (!if_req || (state_q == REQ_IF && bus_gnt))
      starve_d = '0;
    else if (state_q == REQ_MEM && bus_gnt && starve_q != CNT_W'(STARVE_MAX))
      starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign starve_hit = (starve_q == CNT_W'(STARVE_MAX));
`else
  assign starve_hit = 1'b0;
`endif

  // The response cycle is a turnaround: the requester still holds its request
  // while it sees valid, so nothing is arbitrated until it has moved on.
  assign arb_open = ~(if_valid_q | mem_valid_q);

  arb_select u_arb_select (
    .mem_req    (mem_req & arb_open),
    .if_req     (if_req & ~if_flush & arb_open),
    .starve_hit (starve_hit),
    .pick_mem   (pick_mem),
    .pick_if    (pick_if)
  );

  always_comb begin
    // NOTE: every _d starts from a default so no branch leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    drop_d      = drop_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    rdata_d     = '0;
    case (state_q)
      IDLE: begin
        if (pick_mem) begin
          state_d = REQ_MEM;
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          be_d    = mem_be;
        end else if (pick_if) begin
          state_d = REQ_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          be_d    = '1;
        end
      end
      REQ_IF: begin
        if (bus_gnt) begin
          state_d = WAIT_IF;
          drop_d  = if_flush;
        end else if (if_flush) begin
          state_d = IDLE;
        end
      end
      REQ_MEM: if (bus_gnt) state_d = WAIT_MEM;
      WAIT_IF: begin
        if (bus_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!(drop_q || if_flush)) begin
            if_valid_d = 1'b1;
            rdata_d    = bus_rdata;
          end
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end
      WAIT_MEM: begin
        if (bus_rvalid) begin
          state_d     = IDLE;
          mem_valid_d = 1'b1;
          rdata_d     = bus_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_req   = (state_q == REQ_IF) || (state_q == REQ_MEM);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? addr_q : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;
  assign bus_be    = bus_req ? be_q : '0;

  assign if_valid  = if_valid_q;
  assign mem_valid = mem_valid_q;
  assign if_rdata  = if_valid_q ? rdata_q : '0;
  assign mem_rdata = mem_valid_q ? rdata_q : '0;
  assign if_stall  = if_req & ~if_valid_q;
  assign mem_stall = mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected bus
// commands and responses; a monitor pops and compares as the DUT presents them.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_flush, if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req, mem_we, mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;
  logic              if_stall, mem_stall;
  logic              bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata, bus_rdata;
  logic [BE_W-1:0]   bus_be;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [68:0] exp_cmd_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];
  int n_acc = 0, last_acc_cyc = 0;
  int n_if_valid = 0, n_mem_valid = 0, n_rvalid = 0;

  int          gnt_delay = 0, rv_delay = 1;
  int          hold_cnt = 0, rv_left = 0;
  bit          busy = 0, g_prev = 0;
  logic [31:0] rv_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual %s required %s", name, act, req);
  endtask

  // Hand-written memory contents.
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h00A0_0113;
      32'h0000_0108: return 32'h0000_0013;
      32'h0000_0140: return 32'h0010_0073;
      32'h0000_0200: return 32'hBAD0_BAD0;
      32'h0000_0300: return 32'h1122_3344;
      32'h0000_2000: return 32'hCAFE_0001;
      32'h0000_5000: return 32'h55AA_55AA;
      32'h0000_6000: return 32'h6000_6000;
      default:       return 32'hDEAD_0000 ^ a;
    endcase
  endfunction

  // Memory responder: grant after gnt_delay requesting cycles, respond rv_delay cycles later.
  initial begin
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      if (g_prev) begin
        g_prev  = 1'b0;
        bus_gnt = 1'b0;
        rv_left = rv_delay;
      end
      if (rv_left > 0) begin
        rv_left--;
        if (rv_left == 0) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rv_data;
          busy       = 1'b0;
        end
      end else if (!busy) begin
        if (!bus_req) hold_cnt = 0;
        else if (hold_cnt < gnt_delay) hold_cnt++;
        else begin
          bus_gnt  = 1'b1;
          g_prev   = 1'b1;
          busy     = 1'b1;
          hold_cnt = 0;
          rv_data  = bus_we ? 32'h0 : model_rd(bus_addr);
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (bus_req && bus_gnt) begin
        n_acc++;
        last_acc_cyc = cycle;
        if (exp_cmd_q.size() == 0) fail_now("bus_cmd_unexpected", "command accepted", "no command");
        else check("bus_cmd", {bus_we, bus_addr, bus_wdata, bus_be}, exp_cmd_q.pop_front());
      end
      if (!bus_req && mem_req) check("bus_idle_zero", {bus_we, bus_wdata, bus_be}, '0);
      if (bus_rvalid) n_rvalid++;
      if (if_valid) begin
        n_if_valid++;
        if (exp_if_q.size() == 0) fail_now("if_valid_unexpected", "if_valid=1", "if_valid=0");
        else check("if_rdata", if_rdata, exp_if_q.pop_front());
      end else if (bus_rvalid) check("if_rdata_idle", if_rdata, '0);
      if (mem_valid) begin
        n_mem_valid++;
        if (exp_mem_q.size() == 0) fail_now("mem_valid_unexpected", "mem_valid=1", "mem_valid=0");
        else check("mem_rdata", mem_rdata, exp_mem_q.pop_front());
      end else if (bus_rvalid) check("mem_rdata_idle", mem_rdata, '0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual still running required finished");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input bit is_mem, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk); #1;
      seen = is_mem ? mem_valid : if_valid;
    end
    if (!seen) fail_now(is_mem ? "timeout_mem_valid" : "timeout_if_valid", "no valid", "valid");
  endtask

  task automatic wait_accept(input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk); #1;
      seen = bus_req && bus_gnt;
    end
    if (!seen) fail_now("timeout_accept", "no acceptance", "acceptance");
  endtask

  initial begin
    int mv_cyc, acc0, hold, cnt0, rv0;
    bit got;
    reset = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_be = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctrl", {bus_req, bus_we, if_valid, mem_valid, if_stall, mem_stall}, '0);
    check("reset_bus", {bus_addr, bus_wdata, bus_be}, '0);
    check("reset_rdata", {if_rdata, mem_rdata}, '0);
    tick(); reset = 1'b0;

    // Plain fetch: valid in cycle 3, stall in cycles 0-2.
    tick();
    if_req = 1; if_addr = 32'h100;
    exp_cmd_q.push_back({1'b0, 32'h100, 32'h0, 4'hF});
    exp_if_q.push_back(32'h0050_0093);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("t1_if_stall_c%0d", k), if_stall, k < 3);
      check($sformatf("t1_if_valid_c%0d", k), if_valid, k == 3);
    end
    tick(); if_req = 0;

    // Simultaneous load and fetch: data first, fetch only after mem_valid.
    tick();
    mem_req = 1; mem_we = 0; mem_addr = 32'h2000; mem_be = 4'hF;
    if_req = 1; if_addr = 32'h104;
    exp_cmd_q.push_back({1'b0, 32'h2000, 32'h0, 4'hF});
    exp_cmd_q.push_back({1'b0, 32'h104, 32'h0, 4'hF});
    exp_mem_q.push_back(32'hCAFE_0001);
    exp_if_q.push_back(32'h00A0_0113);
    wait_valid(1'b1, 20);
    mv_cyc = cycle;
    tick(); mem_req = 0;
    wait_valid(1'b0, 20);
    check("t2_fetch_after_mem_valid", last_acc_cyc > mv_cyc, 1'b1);
    tick(); if_req = 0;

    // Write held off by bus_gnt for 5 cycles.
    gnt_delay = 5;
    tick();
    mem_req = 1; mem_we = 1; mem_addr = 32'h3000; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'hF;
    exp_cmd_q.push_back({1'b1, 32'h3000, 32'hDEAD_BEEF, 4'hF});
    exp_mem_q.push_back(32'h0);
    acc0 = n_acc; hold = 0; got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      if (bus_req && !bus_gnt) begin
        hold++;
        check("t3_hold_fields", {bus_we, bus_addr, bus_wdata, bus_be},
              {1'b1, 32'h3000, 32'hDEAD_BEEF, 4'hF});
      end
      if (mem_valid) got = 1;
    end
    check("t3_mem_valid_seen", got, 1'b1);
    check("t3_hold_cycles", hold, 5);
    check("t3_single_accept", n_acc - acc0, 1);
    tick(); mem_req = 0; mem_we = 0; mem_wdata = '0;

    // Flush while waiting for grant: command abandoned, redirect fetched.
    gnt_delay = 2;
    tick();
    if_req = 1; if_addr = 32'h400;
    tick();
    if_flush = 1; if_addr = 32'h108;
    @(negedge clk); #1;
    check("t4_in_req_if", bus_req, 1'b1);
    tick(); if_flush = 0;
    @(negedge clk); #1;
    check("t4_flush_drops_req", bus_req, 1'b0);
    exp_cmd_q.push_back({1'b0, 32'h108, 32'h0, 4'hF});
    exp_if_q.push_back(32'h0000_0013);
    wait_valid(1'b0, 20);
    tick(); if_req = 0;
    gnt_delay = 0;

    // Flush in WAIT_IF: response swallowed, redirect served.
    rv_delay = 3;
    tick();
    if_req = 1; if_addr = 32'h200;
    exp_cmd_q.push_back({1'b0, 32'h200, 32'h0, 4'hF});
    exp_cmd_q.push_back({1'b0, 32'h300, 32'h0, 4'hF});
    exp_if_q.push_back(32'h1122_3344);
    cnt0 = n_if_valid;
    wait_accept(20);
    tick(); if_flush = 1; if_addr = 32'h300;
    tick(); if_flush = 0;
    wait_valid(1'b0, 30);
    check("t5_single_if_valid", n_if_valid - cnt0, 1);
    tick(); if_req = 0;

    // Reset during WAIT_MEM; the late response must be ignored.
    rv_delay = 4;
    tick();
    mem_req = 1; mem_we = 0; mem_addr = 32'h5000; mem_be = 4'hF;
    exp_cmd_q.push_back({1'b0, 32'h5000, 32'h0, 4'hF});
    wait_accept(20);
    tick(); reset = 1; mem_req = 0;
    @(negedge clk); #1;
    check("t6_reset_ctrl", {bus_req, if_valid, mem_valid, if_stall, mem_stall}, '0);
    check("t6_reset_bus", {bus_addr, bus_wdata, bus_be}, '0);
    tick(); tick(); reset = 0;
    cnt0 = n_mem_valid; rv0 = n_rvalid;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check($sformatf("t6_bus_idle_%0d", i), bus_req, 1'b0);
    end
    check("t6_late_rvalid_seen", n_rvalid > rv0, 1'b1);
    check("t6_no_mem_valid", n_mem_valid - cnt0, 0);
    rv_delay = 1;
    tick();
    if_req = 1; if_addr = 32'h100;
    exp_cmd_q.push_back({1'b0, 32'h100, 32'h0, 4'hF});
    exp_if_q.push_back(32'h0050_0093);
    wait_valid(1'b0, 10);
    tick(); if_req = 0;

`ifdef ARB_STARVE_GUARD_EN
    // Continuous data traffic: fetch admitted after 4 data grants.
    begin
      int n_data = 0, mv = 0, iv = 0;
      bit got_fetch = 0;
      tick();
      mem_req = 1; mem_we = 0; mem_addr = 32'h6000; mem_be = 4'hF;
      if_req = 1; if_addr = 32'h140;
      for (int i = 0; i < 4; i++) exp_cmd_q.push_back({1'b0, 32'h6000, 32'h0, 4'hF});
      exp_cmd_q.push_back({1'b0, 32'h140, 32'h0, 4'hF});
      exp_cmd_q.push_back({1'b0, 32'h6000, 32'h0, 4'hF});
      for (int i = 0; i < 5; i++) exp_mem_q.push_back(32'h6000_6000);
      exp_if_q.push_back(32'h0010_0073);
      for (int i = 0; i < 300 && (mv < 5 || iv < 1); i++) begin
        @(negedge clk); #1;
        if (bus_req && bus_gnt && !got_fetch) begin
          if (bus_addr == 32'h140) got_fetch = 1;
          else n_data++;
        end
        if (if_valid) begin iv++; if_req = 0; end
        if (mem_valid) begin mv++; if (mv == 5) mem_req = 0; end
      end
      check("t7_done", (mv >= 5) && (iv >= 1), 1'b1);
      check("t7_data_before_fetch", n_data, 4);
    end
`endif

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_cmd_q.size() + exp_if_q.size() + exp_mem_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
